// File: rtl/dmem_pkg.sv
// Shared constants for the data-side memory subsystem: MMIO map and STATUS bit layout.
package dmem_pkg;

  localparam logic [31:0] ADDR_CONSOLE = 32'h0000_0100;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_0104;
  localparam logic [31:0] ADDR_CYCLE   = 32'h0000_0108;
  localparam logic [31:0] ADDR_HALT    = 32'h0000_010C;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_CON,
    SEL_STAT,
    SEL_CYC,
    SEL_HALT
  } sel_e;

  // Word-granular match: byte-offset bits are ignored.
  function automatic logic word_match(input logic [31:0] addr, input logic [31:0] reg_addr);
    return addr[31:2] == reg_addr[31:2];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a pop in the same cycle frees room for a push when full.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  // Storage is not reset; empty gating keeps the head at zero after a flush.
  assign o_dout  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_subsystem.sv
// Data RAM plus MMIO window (console FIFO, STATUS, CYCLE, HALT) behind the CPU data port.
// Optional feature: define DMEM_CYCLE_COUNTER_EN to implement the CYCLE counter.
module dmem_mmio_subsystem
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] data_in,
  output logic [31:0] con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        halt
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0]   r_ram [DEPTH_WORDS];
  logic          r_halt, r_ovf;
  sel_e          w_sel;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata, w_status, w_cycle;
  logic          w_full, w_empty, w_pop, w_con_push, w_stat_wr;

  assign w_idx = data_addr[AW+1:2];

  always_comb begin
    w_sel = SEL_NONE;
    if (data_addr < RAM_BYTES)                  w_sel = SEL_RAM;
    else if (word_match(data_addr, ADDR_CONSOLE)) w_sel = SEL_CON;
    else if (word_match(data_addr, ADDR_STATUS))  w_sel = SEL_STAT;
    else if (word_match(data_addr, ADDR_CYCLE))   w_sel = SEL_CYC;
    else if (word_match(data_addr, ADDR_HALT))    w_sel = SEL_HALT;
  end

  assign w_con_push = mem_write && (w_sel == SEL_CON);
  assign w_stat_wr  = mem_write && (w_sel == SEL_STAT);
  assign w_pop      = con_valid && con_ready;

  sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_con_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_con_push),
    .i_din   (data_out),
    .i_pop   (w_pop),
    .o_dout  (con_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign con_valid = !w_empty;
  assign halt      = r_halt;

  always_ff @(posedge clk) begin
    if (mem_write && (w_sel == SEL_RAM)) r_ram[w_idx] <= data_out;
  end

  // A drop in the same cycle as a W1C leaves overflow set: the new event wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf  <= 1'b0;
      r_halt <= 1'b0;
    end else begin
      if (w_con_push && w_full && !w_pop)       r_ovf <= 1'b1;
      else if (w_stat_wr && data_out[ST_OVF])   r_ovf <= 1'b0;
      if (mem_write && (w_sel == SEL_HALT) && (|data_out)) r_halt <= 1'b1;
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_cycle <= '0;
    else if (!r_halt) r_cycle <= r_cycle + 32'd1;
  end
  assign w_cycle = r_cycle;
`else
  assign w_cycle = '0;
`endif

  always_comb begin
    w_status           = '0;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL]  = w_full;
    w_status[ST_OVF]   = r_ovf;
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_RAM:  w_rdata = r_ram[w_idx];
      SEL_STAT: w_rdata = w_status;
      SEL_CYC:  w_rdata = w_cycle;
      SEL_HALT: w_rdata = {31'b0, r_halt};
      default:  w_rdata = '0;
    endcase
  end

  assign data_in = mem_read ? w_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_mmio_subsystem.sv
// Scoreboard bench for dmem_mmio_subsystem: stimulus queues expected loads and console words,
// negedge monitors pop and compare.
module tb_dmem_mmio_subsystem;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_out  = '0;
  logic        mem_write = 1'b0;
  logic        mem_read  = 1'b0;
  logic        con_ready = 1'b0;
  logic [31:0] data_in, con_data;
  logic        con_valid, halt;

  dmem_mmio_subsystem #(.DEPTH_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_addr (data_addr),
    .data_out  (data_out),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .data_in   (data_in),
    .con_data  (con_data),
    .con_valid (con_valid),
    .con_ready (con_ready),
    .halt      (halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        rd_q[$];
  logic [31:0] con_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Reference cycle counter: counts edges out of reset, freezes once a nonzero HALT store lands.
  int unsigned cyc_mdl;
  bit          halt_mdl;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_mdl  = 0;
      halt_mdl = 0;
    end else begin
      if (!halt_mdl) cyc_mdl = cyc_mdl + 1;
      if (mem_write && data_addr == ADDR_HALT && data_out != 0) halt_mdl = 1;
    end
  end

  function automatic logic [31:0] cyc_exp();
`ifdef DMEM_CYCLE_COUNTER_EN
    return cyc_mdl;
`else
    return 32'd0;
`endif
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] w;
    if (mem_read) begin
      n_vec++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: data_in=%h with no load queued", data_in);
      end else begin
        e = rd_q.pop_front();
        if (data_in !== e.exp) begin
          n_err++;
          $display("FAIL %s: data_in=%h expected %h", e.name, data_in, e.exp);
        end
      end
    end
    if (con_valid && con_ready) begin
      n_vec++;
      if (con_q.size() == 0) begin
        n_err++;
        $display("FAIL con_unexpected: con_data=%h with no word queued", con_data);
      end else begin
        w = con_q.pop_front();
        if (con_data !== w) begin
          n_err++;
          $display("FAIL con_data: got %h expected %h", con_data, w);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    data_addr = a;
    data_out  = d;
    mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  task automatic rd(input string n, input logic [31:0] a, input logic [31:0] e);
    data_addr = a;
    mem_read  = 1'b1;
    rd_q.push_back('{n, e});
    @(negedge clk);
    @(posedge clk);
    #1;
    mem_read = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input bit accepted);
    if (accepted) con_q.push_back(d);
    wr(ADDR_CONSOLE, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_con_valid", {31'b0, con_valid}, 32'd0);
    chk("rst_con_data", con_data, 32'd0);
    chk("rst_halt", {31'b0, halt}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    rd("status_rst", ADDR_STATUS, 32'h1);
    wr(ADDR_HALT, 32'd0);
    chk("halt_zero_write", {31'b0, halt}, 32'd0);
    rd("halt_rd_zero", ADDR_HALT, 32'd0);

    // RAM round trip, same-cycle read/write, unmapped reads
    wr(32'h10, 32'hDEADBEEF);
    rd("ram_0x10", 32'h10, 32'hDEADBEEF);
    wr(32'h14, 32'h5);
    rd("ram_0x14", 32'h14, 32'h5);
    rd("ram_0x10_keep", 32'h10, 32'hDEADBEEF);
    rd("unmapped_0x200", 32'h200, 32'd0);
    rd("console_rd", ADDR_CONSOLE, 32'd0);
    data_addr = 32'h10; data_out = 32'h1234; mem_write = 1'b1;
    rd("rd_wr_same", 32'h10, 32'hDEADBEEF);
    mem_write = 1'b0;
    rd("ram_after_rw", 32'h10, 32'h1234);
    wr(32'hFC, 32'hA5A5_0001);
    rd("ram_top_word", 32'hFC, 32'hA5A5_0001);
    rd("ram_byte_ofs", 32'h13, 32'h1234);

    // cycle counter some way out of reset
    repeat (80) @(posedge clk);
    #1;
    rd("cycle_run", ADDR_CYCLE, cyc_exp());

    // FIFO ordering with consumer stalled, then drained
    push(32'd1, 1'b1);
    push(32'd2, 1'b1);
    push(32'd3, 1'b1);
    rd("status_3", ADDR_STATUS, 32'h0);
    con_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    con_ready = 1'b0;
    chk("con_valid_drained", {31'b0, con_valid}, 32'd0);
    rd("status_empty", ADDR_STATUS, 32'h1);

    // overflow: nine pushes into eight entries
    for (int i = 1; i <= 9; i++) push(32'(i), i <= 8);
    rd("status_ovf", ADDR_STATUS, 32'h6);
    wr(ADDR_STATUS, 32'h4);
    rd("status_w1c", ADDR_STATUS, 32'h2);
    con_ready = 1'b1;
    push(32'd100, 1'b1);
    con_ready = 1'b0;
    rd("status_full_pop", ADDR_STATUS, 32'h2);
    con_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    con_ready = 1'b0;
    rd("status_after_drain", ADDR_STATUS, 32'h1);

    // halt freezes the counter; RAM and FIFO stay live
    wr(ADDR_HALT, 32'h1);
    chk("halt_set", {31'b0, halt}, 32'd1);
    rd("cycle_halt_a", ADDR_CYCLE, cyc_exp());
    repeat (10) @(posedge clk);
    #1;
    rd("cycle_halt_b", ADDR_CYCLE, cyc_exp());
    rd("halt_rd_one", ADDR_HALT, 32'h1);
    wr(32'h20, 32'hCAFEF00D);
    rd("ram_after_halt", 32'h20, 32'hCAFEF00D);

    // asynchronous reset in the middle of a cycle
    push(32'd7, 1'b1);
    push(32'd8, 1'b1);
    push(32'd9, 1'b1);
    rd("status_pre_rst", ADDR_STATUS, 32'h0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_con_valid", {31'b0, con_valid}, 32'd0);
    chk("async_halt", {31'b0, halt}, 32'd0);
    chk("async_con_data", con_data, 32'd0);
    con_q.delete();
    rd("ram_kept_rst", 32'h20, 32'hCAFEF00D);
    rst = 1'b1;
    rd("status_post_rst", ADDR_STATUS, 32'h1);
    repeat (20) @(posedge clk);
    #1;
    rd("cycle_post_rst", ADDR_CYCLE, cyc_exp());

    repeat (2) @(posedge clk);
    n_vec++;
    if (rd_q.size() != 0 || con_q.size() != 0) begin
      n_err++;
      $display("FAIL queues_drained: rd_q=%0d con_q=%0d left, expected 0", rd_q.size(), con_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_subsystem.md
# dmem_mmio_subsystem

- Data-side memory subsystem that sits directly downstream of the 5-stage `cpu` data port (`data_addr`, `data_out`, `data_in`, `mem_write`, `mem_read`).
- Provides word RAM with combinational read and synchronous write.
- Adds a small MMIO window:
  - console FIFO drained through a valid/ready port,
  - FIFO status register,
  - cycle counter,
  - sticky `halt` flag that program code sets to signal completion to benches and the top level.

## Interface

Parameters:
- `DEPTH_WORDS`, 64 — RAM size in 32-bit words; power of 2, at most 64.
- `FIFO_DEPTH`, 8 — console FIFO entries; power of 2, at least 2.

Ports:
- `clk`  in  1  — system clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `data_addr`  in  32  — CPU byte address; bits [1:0] ignored.
- `data_out`  in  32  — CPU store data.
- `mem_write`  in  1  — store strobe, sampled at the rising edge.
- `mem_read`  in  1  — load strobe.
- `data_in`  out  32  — load data, combinational from address.
- `con_data`  out  32  — FIFO head word.
- `con_valid`  out  1  — FIFO non-empty.
- `con_ready`  in  1  — consumer accepts the head word.
- `halt`  out  1  — sticky program-done flag.

## Operation

Address decode, on word address `data_addr[31:2]`:
- RAM region: `data_addr < 4*DEPTH_WORDS`; index `data_addr[log2(DEPTH_WORDS)+1:2]`.
- `0x100` CONSOLE
  - Write: push `data_out`.
  - Read: returns 0.
- `0x104` STATUS
  - Read: `{29'b0, overflow, full, empty}`.
  - Write: bit 2 = 1 clears `overflow` (W1C); all other bits ignored.
- `0x108` CYCLE
  - Read: 32-bit counter value.
  - Write: ignored.
- `0x10C` HALT
  - Write of any nonzero value sets `halt`; a zero write is ignored.
  - Read: `{31'b0, halt}`.
- Any other address: read returns 0; write ignored.

Reads and writes:
- `data_in` = decoded value while `mem_read`=1; otherwise 0.
- `mem_read` and `mem_write` in the same cycle to the same address: `data_in` shows the pre-write value.
- RAM contents are not reset.

Console FIFO (show-ahead):
- `con_data` = head; `con_valid` = !empty.
- Pop when `con_valid && con_ready`.
- Push when full with no pop: word dropped, `overflow` set (sticky).
- Push when full together with a pop: accepted; count unchanged.
- Push when empty: `con_valid` rises the next cycle.
- Pointers wrap modulo `FIFO_DEPTH`; count is held in a `log2(FIFO_DEPTH)+1`-bit counter.

Cycle counter:
- Increments every cycle after reset deassertion; wraps 0xFFFFFFFF→0.
- Freezes while `halt`=1.

Halt:
- Cleared only by reset.
- RAM, FIFO and STATUS stay fully functional after halt.

## Timing

- Reset values:
  - `con_valid`=0, `con_data`=0, `halt`=0.
  - `overflow`=0, FIFO empty, pointers 0, cycle counter 0.
  - `data_in` follows its combinational rule.
- Load latency: 0 cycles (combinational `data_in`).
- Store latency: visible to a read 1 cycle after the write edge.
- CONSOLE push → `con_valid`: 1 cycle.
- Reset asserted mid-operation: FIFO is flushed and `halt`/`overflow`/counter are cleared immediately (asynchronously). RAM contents are retained.

## Configuration

- `DMEM_CYCLE_COUNTER_EN` defined: the CYCLE register is implemented as described above.
- Undefined:
  - No counter flops are synthesized.
  - A CYCLE read returns 0.
  - A halt has no counter effect.

## Structure

- Package `dmem_pkg`:
  - MMIO address constants: `ADDR_CONSOLE`, `ADDR_STATUS`, `ADDR_CYCLE`, `ADDR_HALT`.
  - STATUS bit indices: `ST_EMPTY`=0, `ST_FULL`=1, `ST_OVF`=2.
- Sub-module `sync_fifo`:
  - Parameterized width and depth.
  - Show-ahead output; push/pop; full/empty.
  - Pop-enables-push-when-full behaviour.
- Top level holds the decode, RAM array, counter, halt and overflow registers.

## Test plan

- RAM round trip: write 0xDEADBEEF @0x10, then read @0x10 → 0xDEADBEEF; read @0x14 after writing 0x5 there → 0x5; read @0x200 → 0.
- FIFO order with `con_ready`=0: push 1,2,3 to 0x100; STATUS read → 0; raise `con_ready` → `con_data` 1,2,3 on consecutive cycles, then `con_valid`=0 and STATUS=1.
- Overflow: with `FIFO_DEPTH`=8 and `con_ready`=0, push 9 words → STATUS=0x6, 9th word absent. Write 0x4 to STATUS → STATUS=0x2. A push while full with `con_ready`=1 is accepted and STATUS stays 0x2.
- Halt/counter (macro defined): release reset, then 100 cycles later read CYCLE → 100±1. Write 1 to 0x10C → `halt`=1 next cycle; CYCLE reads are constant thereafter. A zero write to a fresh HALT leaves `halt`=0.
- Reset mid-run: FIFO holds 3 entries and `halt`=1; assert `rst`=0 → `con_valid`=0 and `halt`=0 without a clock edge; RAM word written before reset reads back unchanged.
- Macro undefined: CYCLE read → 0 after 50 cycles; all other scenarios give identical results.
